if_id_pipe_reg: RTL and testbench
=================================

// Module: if_id_pipe_reg
// PURPOSE
// - Parametrised IF/ID pipeline register for the MIPS core, between fetch (PC + instruction memory) and decode.
// - Captures the instruction and its PC, and forwards the instruction with PC+PC_INC.
// - Adds a valid/ready handshake, stall back-pressure, flush (branch/jump squash) and a 2-entry skid buffer.
//   The skid buffer lets fetch run one beat ahead without a combinational ready path.
// - Keeps a saturating stall-cycle counter for performance visibility.
// PARAMETERS
// - INSTR_W  32  instruction width in bits
// - PC_W     8   PC width in bits; all PC arithmetic is modulo 2^PC_W
// - PC_INC   4   increment added to the captured PC (bytes per instruction)
// - NOP      0   instruction word presented when no valid beat is held (MIPS sll $0,$0,0)
// - CNT_W    16  stall counter width
// PORTS
// - clock        in   1        rising-edge clock, sole clock domain
// - reset        in   1        synchronous, active-high reset
// - in_valid     in   1        fetch presents a beat
// - in_ready     out  1        stage can accept; registered, = !skid_valid
// - instr_in     in   INSTR_W  fetched instruction
// - pc_in        in   PC_W     PC of fetched instruction
// - flush        in   1        squash all held beats (taken branch/jump)
// - out_valid    out  1        beat available to decode
// - out_ready    in   1        decode accepts; low = stall
// - instr_out    out  INSTR_W  held instruction, NOP when !out_valid
// - pc_out       out  PC_W     (pc_in + PC_INC) mod 2^PC_W of held beat, 0 when !out_valid
// - stall_cnt    out  CNT_W    cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
// - Reset: state EMPTY, out_valid=0, in_ready=1, instr_out=NOP, pc_out=0, stall_cnt=0.
//   Reset mid-operation discards all beats in the same edge.
// - accept = in_valid && in_ready; fire = out_valid && out_ready.
// - pc_out is computed at capture (adder on input side) and truncated to PC_W; 8'hFC+4 wraps to 8'h00.
// - Latency: beat accepted at edge N is on the outputs after edge N (out_valid=1 in cycle N+1).
// - FSM, ordered by number of held beats:
//   - EMPTY
//     - accept -> ONE (load main)
//     - else stay
//   - ONE
//     - fire & accept -> ONE (main replaced)
//     - fire & !accept -> EMPTY
//     - !fire & accept -> TWO (new beat into skid)
//     - else stay
//   - TWO (in_ready=0)
//     - fire -> ONE (skid moves to main)
//     - else stay
// - Order is preserved; no beat is ever dropped or duplicated except by flush/reset.
// - flush has priority over everything except reset:
//   - next state EMPTY; a beat accepted in the same cycle is also discarded;
//   - in_ready is 1 the cycle after.
// - flush together with fire: decode still consumes the current beat this cycle.
// - Outputs in EMPTY: instr_out=NOP, pc_out=0. Data registers are not required to clear internally.
// - stall_cnt increments when out_valid && !out_ready, holds at 2^CNT_W-1, and is cleared only by reset.
// STRUCTURE
// - Package mips_pipe_pkg:
//   - state enum {EMPTY, ONE, TWO};
//   - MIPS_NOP constant;
//   - default PC_INC constant.
// - Sub-module if_id_sat_counter (CNT_W, enable, reset) implements stall_cnt; everything else is in this module.
// - Registered outputs only; no combinational path from out_ready to in_ready.
// TESTING
// - Reset, then in_valid=1, pc_in=8'h20, instr_in=32'h8C010004, out_ready=1
//   -> next cycle out_valid=1, pc_out=8'h24, instr_out=32'h8C010004.
// - Stream PCs 0x00,0x04,0x08 with out_ready=0 from cycle 2
//   -> in_ready drops after 2 beats (TWO), stall_cnt counts;
//   -> release out_ready -> outputs 0x04,0x08,0x0C in order, no loss.
// - pc_in=8'hFC accepted -> pc_out=8'h00 (wrap).
// - In TWO, assert flush -> next cycle out_valid=0, instr_out=0 (NOP), pc_out=0, in_ready=1.
//   Simultaneous accept+flush -> beat not emitted.
// - Assert reset while in TWO with stall_cnt=5
//   -> next cycle all outputs at reset values, stall_cnt=0.
// - CNT_W=2, out_ready=0 for 6 cycles with a held beat -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared IF/ID stage types and constants: FSM state encoding, MIPS NOP word, default PC step.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;
    localparam int          DEF_PC_INC = 4;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch-to-decode handshake bundle; slave is the pipeline register, master drives fetch and decode sides.
interface if_id_pipe_reg_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_in;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic [CNT_W-1:0]   stall_cnt;

    modport slave (
        input  in_valid, instr_in, pc_in, flush, out_ready,
        output in_ready, out_valid, instr_out, pc_out, stall_cnt
    );

    modport master (
        output in_valid, instr_in, pc_in, flush, out_ready,
        input  in_ready, out_valid, instr_out, pc_out, stall_cnt
    );
endinterface

// File: rtl/if_id_sat_counter.sv
// Saturating event counter, cleared only by reset; count updates one cycle after enable.
// No backpressure: sticks at all-ones until reset.
module if_id_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID register with 2-entry skid, flush and stall counter; 1-cycle latency from accept to out_valid.
// Backpressure: in_ready is registered and drops only when the skid slot is occupied.
module if_id_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int                 INSTR_W = 32,
    parameter int                 PC_W    = 8,
    parameter int                 PC_INC  = DEF_PC_INC,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(MIPS_NOP),
    parameter int                 CNT_W   = 16
) (
    input  logic           clock,
    input  logic           reset,
    if_id_pipe_reg_if.slave bus
);

    pipe_state_t        state;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    logic               accept;
    logic               fire;
    logic [PC_W-1:0]    pc_next;

    assign accept  = bus.in_valid && bus.in_ready;
    assign fire    = bus.out_valid && bus.out_ready;
    // Incremented PC is formed before capture so the output register holds it directly.
    assign pc_next = bus.pc_in + PC_W'(PC_INC);

    // The main entry doubles as the output register, so it is forced to NOP/0 whenever the stage empties.
    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            state         <= EMPTY;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.instr_out <= NOP;
            bus.pc_out    <= '0;
            skid_instr    <= NOP;
            skid_pc       <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state         <= ONE;
                        bus.out_valid <= 1'b1;
                        bus.instr_out <= bus.instr_in;
                        bus.pc_out    <= pc_next;
                    end
                end
                ONE: begin
                    if (fire && accept) begin
                        bus.instr_out <= bus.instr_in;
                        bus.pc_out    <= pc_next;
                    end else if (fire) begin
                        state         <= EMPTY;
                        bus.out_valid <= 1'b0;
                        bus.instr_out <= NOP;
                        bus.pc_out    <= '0;
                    end else if (accept) begin
                        state        <= TWO;
                        bus.in_ready <= 1'b0;
                        skid_instr   <= bus.instr_in;
                        skid_pc      <= pc_next;
                    end
                end
                TWO: begin
                    if (fire) begin
                        state         <= ONE;
                        bus.in_ready  <= 1'b1;
                        bus.instr_out <= skid_instr;
                        bus.pc_out    <= skid_pc;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.instr_out <= NOP;
                    bus.pc_out    <= '0;
                end
            endcase
        end
    end

    if_id_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.out_valid && !bus.out_ready),
        .count  (bus.stall_cnt)
    );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed vector bench for the IF/ID pipeline register plus a narrow-counter saturation instance.
module tb_if_id_pipe_reg;

    logic clock;
    logic reset;

    int total;
    int bad;

    if_id_pipe_reg_if #(.INSTR_W(32), .PC_W(8), .CNT_W(16)) bus  ();
    if_id_pipe_reg_if #(.INSTR_W(32), .PC_W(8), .CNT_W(2))  bus2 ();

    if_id_pipe_reg #(.INSTR_W(32), .PC_W(8), .PC_INC(4), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    if_id_pipe_reg #(.INSTR_W(32), .PC_W(8), .PC_INC(4), .CNT_W(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [7:0]  pc;
        logic        fl;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic [31:0] einstr;
        logic [7:0]  epc;
        logic [15:0] estall;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic iv, input logic [31:0] instr, input logic [7:0] pc,
                                input logic fl, input logic ordy, input logic eov, input logic eir,
                                input logic [31:0] einstr, input logic [7:0] epc, input logic [15:0] estall);
        vec_t v;
        v.iv = iv; v.instr = instr; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.eov = eov; v.eir = eir; v.einstr = einstr; v.epc = epc; v.estall = estall;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic eov, input logic eir,
                                 input logic [31:0] einstr, input logic [7:0] epc, input logic [15:0] estall);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(eov));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(eir));
        check({tag, ".instr_out"}, bus.instr_out,      einstr);
        check({tag, ".pc_out"},    32'(bus.pc_out),    32'(epc));
        check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(estall));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //  iv    instr         pc     fl    ordy | ov    ir    instr         pc     stall
        add(1'b1, 32'h8C010004, 8'h20, 1'b0, 1'b1,  1'b1, 1'b1, 32'h8C010004, 8'h24, 16'd0);
        add(1'b0, 32'h0,        8'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h0,        8'h00, 16'd0);
        add(1'b1, 32'hA0,       8'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'hA0,       8'h04, 16'd0);
        add(1'b1, 32'hA1,       8'h04, 1'b0, 1'b0,  1'b1, 1'b0, 32'hA0,       8'h04, 16'd1);
        add(1'b1, 32'hA2,       8'h08, 1'b0, 1'b0,  1'b1, 1'b0, 32'hA0,       8'h04, 16'd2);
        add(1'b1, 32'hA2,       8'h08, 1'b0, 1'b0,  1'b1, 1'b0, 32'hA0,       8'h04, 16'd3);
        add(1'b1, 32'hA2,       8'h08, 1'b0, 1'b1,  1'b1, 1'b1, 32'hA1,       8'h08, 16'd3);
        add(1'b1, 32'hA2,       8'h08, 1'b0, 1'b1,  1'b1, 1'b1, 32'hA2,       8'h0C, 16'd3);
        add(1'b0, 32'h0,        8'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h0,        8'h00, 16'd3);
        add(1'b1, 32'hB0,       8'hFC, 1'b0, 1'b0,  1'b1, 1'b1, 32'hB0,       8'h00, 16'd3);
        add(1'b0, 32'h0,        8'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h0,        8'h00, 16'd3);
        add(1'b1, 32'hC0,       8'h10, 1'b0, 1'b0,  1'b1, 1'b1, 32'hC0,       8'h14, 16'd3);
        add(1'b1, 32'hC1,       8'h14, 1'b0, 1'b0,  1'b1, 1'b0, 32'hC0,       8'h14, 16'd4);
        add(1'b0, 32'h0,        8'h00, 1'b1, 1'b1,  1'b0, 1'b1, 32'h0,        8'h00, 16'd4);
        add(1'b1, 32'hC2,       8'h18, 1'b1, 1'b1,  1'b0, 1'b1, 32'h0,        8'h00, 16'd4);
        add(1'b0, 32'h0,        8'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h0,        8'h00, 16'd4);
        add(1'b1, 32'hD0,       8'h20, 1'b0, 1'b1,  1'b1, 1'b1, 32'hD0,       8'h24, 16'd4);
        add(1'b0, 32'h0,        8'h00, 1'b1, 1'b1,  1'b0, 1'b1, 32'h0,        8'h00, 16'd4);
        add(1'b1, 32'hE0,       8'h30, 1'b0, 1'b1,  1'b1, 1'b1, 32'hE0,       8'h34, 16'd4);
        add(1'b1, 32'hE1,       8'h34, 1'b0, 1'b0,  1'b1, 1'b0, 32'hE0,       8'h34, 16'd5);

        reset         = 1'b1;
        bus.in_valid  = 1'b0; bus.instr_in  = 32'h0; bus.pc_in  = 8'h0; bus.flush  = 1'b0; bus.out_ready  = 1'b0;
        bus2.in_valid = 1'b0; bus2.instr_in = 32'h0; bus2.pc_in = 8'h0; bus2.flush = 1'b0; bus2.out_ready = 1'b0;
        step();
        step();
        check_outputs("reset", 1'b0, 1'b1, 32'h0, 8'h00, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            bus.in_valid  = vq[i].iv;
            bus.instr_in  = vq[i].instr;
            bus.pc_in     = vq[i].pc;
            bus.flush     = vq[i].fl;
            bus.out_ready = vq[i].ordy;
            step();
            check_outputs($sformatf("vec%0d", i), vq[i].eov, vq[i].eir, vq[i].einstr, vq[i].epc, vq[i].estall);
        end

        // Reset while holding two beats with stall_cnt=5; a beat offered during reset must not appear.
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'hF0;
        bus.pc_in     = 8'h50;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        step();
        check_outputs("reset_in_two", 1'b0, 1'b1, 32'h0, 8'h00, 16'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check_outputs("post_reset_idle", 1'b0, 1'b1, 32'h0, 8'h00, 16'd0);
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'h8C020008;
        bus.pc_in     = 8'h60;
        bus.out_ready = 1'b1;
        step();
        check_outputs("post_reset_accept", 1'b1, 1'b1, 32'h8C020008, 8'h64, 16'd0);
        bus.in_valid = 1'b0;

        // Narrow counter: hold one beat with decode stalled and watch it saturate at 3.
        bus2.in_valid  = 1'b1;
        bus2.instr_in  = 32'h1234;
        bus2.pc_in     = 8'h40;
        bus2.out_ready = 1'b0;
        step();
        check("sat.load_valid", 32'(bus2.out_valid), 32'd1);
        check("sat.load_stall", 32'(bus2.stall_cnt), 32'd0);
        bus2.in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("sat.cycle%0d", k), 32'(bus2.stall_cnt), (k < 3) ? 32'(k) : 32'd3);
        end
        check("sat.held_pc", 32'(bus2.pc_out), 32'h44);
        check("sat.held_valid", 32'(bus2.out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
